// File: rtl/seq_alu.sv
// seq_alu: multicycle ALU with start/busy/done handshake.
// Define SEQ_ALU_DIV_EN to build the restoring divider for op 111.
module seq_alu #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam int MUL_CYC = WIDTH / MUL_STEP;
    localparam int CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;

    logic             sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c;
    logic [3:0]       flg_c;
    logic             go_mul;
    logic             go_div;
    logic [WIDTH-1:0] mul_term;
    logic [WIDTH-1:0] acc_nx;

    function automatic logic [3:0] nz(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], (r == '0), 2'b00};
    endfunction

    // single-cycle result and flags, computed from the operands being accepted
    always_comb begin
        sub   = (ALUControl == 3'b001);
        sum   = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
        res_c = '0;
        unique case (ALUControl)
            3'b000, 3'b001: res_c = sum[WIDTH-1:0];
            3'b010:         res_c = a & b;
            3'b011:         res_c = a | b;
            3'b100:         res_c = a ^ b;
            3'b101:         res_c = b;
`ifdef SEQ_ALU_DIV_EN
            3'b111:         res_c = '1;
`else
            3'b111:         res_c = '0;
`endif
            default:        res_c = '0;
        endcase
        flg_c = nz(res_c);
        if (ALUControl == 3'b000 || sub) begin
            flg_c[1] = sum[WIDTH];
            flg_c[0] = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) &
                       (a[WIDTH-1] ^ sum[WIDTH-1]);
        end
        go_mul = (ALUControl == 3'b110);
`ifdef SEQ_ALU_DIV_EN
        go_div = (ALUControl == 3'b111) && (b != '0);
`else
        go_div = 1'b0;
`endif
    end

    // one shift-add step of the multiplier
    always_comb begin
        mul_term = a_sh * {{(WIDTH-MUL_STEP){1'b0}}, b_sh[MUL_STEP-1:0]};
        acc_nx   = acc + mul_term;
    end

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // one restoring-divide step: shift in next dividend bit, try subtract
    always_comb begin
        div_sh = {rem, quo[WIDTH-1]};
        div_ge = (div_sh >= {1'b0, dvs});
        rem_nx = div_ge ? WIDTH'(div_sh - {1'b0, dvs}) : div_sh[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], div_ge};
    end

    // divider datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if ((state == IDLE || state == DONE) && start && go_div) begin
            rem <= '0;
            quo <= a;
            dvs <= b;
        end else if (state == DIV) begin
            rem <= rem_nx;
            quo <= quo_nx;
        end
    end
`endif

    // control FSM with registered handshake, result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Result   <= '0;
            ALUFlags <= '0;
            cnt      <= '0;
            acc      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (!start) begin
                        state <= IDLE;
                    end else if (go_mul) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        cnt   <= CW'(MUL_CYC - 1);
                        busy  <= 1'b1;
                        state <= MUL;
                    end else if (go_div) begin
                        cnt   <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= DIV;
                    end else begin
                        Result   <= res_c;
                        ALUFlags <= flg_c;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                MUL: begin
                    acc  <= acc_nx;
                    a_sh <= a_sh << MUL_STEP;
                    b_sh <= b_sh >> MUL_STEP;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        Result   <= acc_nx;
                        ALUFlags <= nz(acc_nx);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                DIV: begin
`ifdef SEQ_ALU_DIV_EN
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        Result   <= quo_nx;
                        ALUFlags <= nz(quo_nx);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against a reference model.
// Honours SEQ_ALU_DIV_EN the same way the design does.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ALUControl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic [3:0]  ALUFlags;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .a(a), .b(b), .busy(busy), .done(done),
        .Result(Result), .ALUFlags(ALUFlags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: result, flags and cycles between accept and done
    task automatic ref_op(input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] r,
                          output logic [3:0] f, output int lat);
        logic [32:0] s;
        logic [63:0] p;
        logic        c;
        logic        v;
        c   = 1'b0;
        v   = 1'b0;
        lat = 0;
        r   = '0;
        case (op)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[31:0];
                c = s[32];
                v = (x[31] == y[31]) && (r[31] != x[31]);
            end
            3'd1: begin
                r = x - y;
                c = (x >= y);
                v = (x[31] != y[31]) && (r[31] != x[31]);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = y;
            3'd6: begin
                p   = {32'b0, x} * {32'b0, y};
                r   = p[31:0];
                lat = 8;
            end
            default: begin
`ifdef SEQ_ALU_DIV_EN
                if (y == 0) r = 32'hFFFF_FFFF;
                else begin
                    r   = x / y;
                    lat = 32;
                end
`else
                r = 0;
`endif
            end
        endcase
        f = {r[31], (r == 0), c, v};
    endtask

    // launch one op, scramble inputs after accept, wait for done
    task automatic do_op(input logic [2:0] op, input logic [31:0] x,
                         input logic [31:0] y, output int lat, output int bz);
        @(negedge clk);
        start = 1'b1;
        ALUControl = op;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        ALUControl = 3'($urandom_range(0, 7));
        lat = 0;
        bz = 0;
        while (!done && lat < 100) begin
            if (busy) bz++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_chk(input string tag, input logic [2:0] op,
                           input logic [31:0] x, input logic [31:0] y);
        logic [31:0] er;
        logic [3:0]  ef;
        int          el;
        int          lat;
        int          bz;
        ref_op(op, x, y, er, ef, el);
        do_op(op, x, y, lat, bz);
        chk({tag, "_lat"}, 64'(lat), 64'(el));
        chk({tag, "_busycyc"}, 64'(bz), 64'(el));
        chk({tag, "_res"}, 64'(Result), 64'(er));
        chk({tag, "_flags"}, 64'(ALUFlags), 64'(ef));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          lat;
        int          bz;
        int          pulses;
        logic [31:0] er;
        logic [3:0]  ef;
        int          el;
        logic [31:0] x;
        logic [31:0] y;

        reset = 1'b1;
        start = 1'b0;
        ALUControl = 3'd0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res", 64'(Result), 64'd0);
        chk("rst_flags", 64'(ALUFlags), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_chk("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_ovf_flags_const", 64'(ALUFlags), 64'b1001);
        chk("add_ovf_res_const", 64'(Result), 64'h8000_0000);
        run_chk("sub_eq", 3'd1, 32'd5, 32'd5);
        chk("sub_eq_flags_const", 64'(ALUFlags), 64'b0110);
        run_chk("sub_neg", 3'd1, 32'd3, 32'd5);
        chk("sub_neg_flags_const", 64'(ALUFlags), 64'b1000);
        run_chk("mul_a", 3'd6, 32'h0001_2345, 32'h0000_0100);
        chk("mul_a_res_const", 64'(Result), 64'h0123_4500);
        run_chk("mul_ones", 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mul_ones_res_const", 64'(Result), 64'd1);
        run_chk("op7_a", 3'd7, 32'd100, 32'd7);
        run_chk("op7_zero", 3'd7, 32'd9, 32'd0);
`ifdef SEQ_ALU_DIV_EN
        chk("div_zero_res_const", 64'(Result), 64'hFFFF_FFFF);
`else
        chk("op7_flags_const", 64'(ALUFlags), 64'b0100);
`endif

        // start held high through a mul: next op only taken in DONE
        @(negedge clk);
        start = 1'b1;
        ALUControl = 3'd6;
        a = 32'h0000_1234;
        b = 32'h0000_0056;
        @(posedge clk);
        #1;
        ALUControl = 3'd0;
        a = 32'h0000_0011;
        b = 32'h0000_0022;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_mul_lat", 64'(lat), 64'd8);
        chk("hold_mul_res", 64'(Result), 64'(32'h1234 * 32'h56));
        @(posedge clk);
        #1;
        chk("hold_add_done", 64'(done), 64'd1);
        chk("hold_add_res", 64'(Result), 64'h33);
        chk("hold_add_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_idle_done", 64'(done), 64'd0);

        // reset held two cycles in the middle of a mul
        @(negedge clk);
        start = 1'b1;
        ALUControl = 3'd6;
        a = 32'h0000_0123;
        b = 32'h0000_0456;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_res", 64'(Result), 64'd0);
        chk("midrst_flags", 64'(ALUFlags), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("midrst_no_done", 64'(pulses), 64'd0);
        chk("midrst_res_hold", 64'(Result), 64'd0);

        // random ops against the model
        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = x;
                1: y = 32'($urandom_range(0, 20));
                default: y = $urandom;
            endcase
            ref_op(3'(i % 8), x, y, er, ef, el);
            do_op(3'(i % 8), x, y, lat, bz);
            chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(el));
            chk($sformatf("rnd%0d_res", i), 64'(Result), 64'(er));
            chk($sformatf("rnd%0d_flags", i), 64'(ALUFlags), 64'(ef));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
